vga_scan_gen: RTL and testbench



---
 rtl/pong_pkg.sv | 17 +
 rtl/vga_axis_cnt.sv | 31 +++
 rtl/vga_scan_gen.sv | 77 +++++++
 tb/tb_vga_scan_gen.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared VGA timing defaults, coordinate width and period helper
package pong_pkg;
  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_MOVE_DIV = 1;
  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: wrapping scan counter for one raster axis with active and sync decode
// Ports: clk, rst_n (async active-low); en advances the count;
//   count current position; wrap high when an enabled advance returns to 0;
//   active count < ACTIVE; sync_n low inside [SYNC_START, SYNC_START+SYNC_W).
module vga_axis_cnt
  import pong_pkg::*;
#(
  parameter int PERIOD = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP,
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int SYNC_START = DEF_H_ACTIVE + DEF_H_FP,
  parameter int SYNC_W = DEF_H_SYNC
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output coord_t count,
  output logic   wrap,
  output logic   active,
  output logic   sync_n
);
  localparam coord_t LAST = COORD_W'(PERIOD - 1);
  localparam coord_t ACT = COORD_W'(ACTIVE);
  localparam coord_t SS = COORD_W'(SYNC_START);
  localparam coord_t SE = COORD_W'(SYNC_START + SYNC_W);
  assign wrap = en && count == LAST;
  assign active = count < ACT;
  assign sync_n = !(count >= SS && count < SE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (en) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster timing source with pixel coordinates and game-step pulse
// Ports: vga_clk pixel clock; sys_rst_n async active-low reset; run gates move_tick;
//   hsync/vsync active-low syncs; video_active visible-area flag;
//   pix_x/pix_y coordinates (0 during blanking); frame_start one-cycle pulse at (0,0);
//   move_tick one-cycle pulse at vblank start every MOVE_DIV frames while run is high.
//   All outputs are registered from the previous cycle's counters, so they stay aligned.
module vga_scan_gen
  import pong_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int MOVE_DIV = DEF_MOVE_DIV
) (
  input  logic                vga_clk,
  input  logic                sys_rst_n,
  input  logic                run,
  output logic                hsync,
  output logic                vsync,
  output logic                video_active,
  output logic [COORD_W-1:0]  pix_x,
  output logic [COORD_W-1:0]  pix_y,
  output logic                frame_start,
  output logic                move_tick
);
  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam coord_t V_BLANK = COORD_W'(V_ACTIVE);
  localparam logic [7:0] DIV_LAST = 8'(MOVE_DIV - 1);
  if (H_TOTAL >= (1 << COORD_W) || V_TOTAL >= (1 << COORD_W) || MOVE_DIV < 1 || MOVE_DIV > 255) begin : g_bad_param
    $error("vga_scan_gen: timing sums must stay below 4096 and MOVE_DIV within 1..255");
  end
  coord_t h_cnt, v_cnt;
  logic h_wrap, v_wrap_unused, h_act, v_act, h_sync_n, v_sync_n, vis, vblank;
  logic [7:0] div;
  vga_axis_cnt #(.PERIOD(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP), .SYNC_W(H_SYNC)) u_h (
    .clk(vga_clk), .rst_n(sys_rst_n), .en(1'b1),
    .count(h_cnt), .wrap(h_wrap), .active(h_act), .sync_n(h_sync_n)
  );
  vga_axis_cnt #(.PERIOD(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP), .SYNC_W(V_SYNC)) u_v (
    .clk(vga_clk), .rst_n(sys_rst_n), .en(h_wrap),
    .count(v_cnt), .wrap(v_wrap_unused), .active(v_act), .sync_n(v_sync_n)
  );
  assign vis = h_act && v_act;
  assign vblank = h_cnt == '0 && v_cnt == V_BLANK;
  always_ff @(posedge vga_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      video_active <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync <= h_sync_n;
      vsync <= v_sync_n;
      video_active <= vis;
      pix_x <= vis ? h_cnt : '0;
      pix_y <= vis ? v_cnt : '0;
      frame_start <= h_cnt == '0 && v_cnt == '0;
    end
  // Divider is pinned at 0 while stopped so the first tick after run rises
  // always lands on the MOVE_DIV-th vblank start.
  always_ff @(posedge vga_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      div <= '0;
      move_tick <= 1'b0;
    end else begin
      move_tick <= run && vblank && div == DIV_LAST;
      div <= !run ? '0 : !vblank ? div : div == DIV_LAST ? '0 : div + 8'd1;
    end
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: self-checking bench comparing three scan generators against a raster model
module tb_vga_scan_gen;
  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FR = HT * VT;
  logic clk = 1'b0, rst_n = 1'b0, run_a = 1'b0, run_b = 1'b0;
  logic hs_a, vs_a, va_a, fs_a, mt_a, hs_b, vs_b, va_b, fs_b, mt_b, hs_d, vs_d, va_d, fs_d, mt_d;
  logic [11:0] px_a, py_a, px_b, py_b, px_d, py_d;
  int checks = 0, errors = 0, k = 0, nva = 0, nvb = 0;
  int fs_cnt = 0, tick_b = 0, hl_cnt = 0, vl_cnt = 0, target = 0;

  always #5 clk = ~clk;

  vga_scan_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
                 .V_SYNC(VS), .V_BP(VB), .MOVE_DIV(3)) dut_a (
    .vga_clk(clk), .sys_rst_n(rst_n), .run(run_a), .hsync(hs_a), .vsync(vs_a),
    .video_active(va_a), .pix_x(px_a), .pix_y(py_a), .frame_start(fs_a), .move_tick(mt_a));
  vga_scan_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
                 .V_SYNC(VS), .V_BP(VB), .MOVE_DIV(2)) dut_b (
    .vga_clk(clk), .sys_rst_n(rst_n), .run(run_b), .hsync(hs_b), .vsync(vs_b),
    .video_active(va_b), .pix_x(px_b), .pix_y(py_b), .frame_start(fs_b), .move_tick(mt_b));
  vga_scan_gen dut_d (
    .vga_clk(clk), .sys_rst_n(rst_n), .run(run_a), .hsync(hs_d), .vsync(vs_d),
    .video_active(va_d), .pix_x(px_d), .pix_y(py_d), .frame_start(fs_d), .move_tick(mt_d));

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, o, e, k);
    end
  endtask

  // Position p of output index kk within the frame determines every raster output.
  task automatic chk_raster(input string n, input int kk, input int ha, input int hfp, input int hsw,
                            input int hbp, input int va, input int vfp, input int vsw, input int vbp,
                            input logic hs_o, input logic vs_o, input logic act_o,
                            input logic [11:0] px, input logic [11:0] py, input logic fs);
    int ht, vt, p, x, y;
    bit a;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    p = kk % (ht * vt);
    x = p % ht;
    y = p / ht;
    a = x < ha && y < va;
    chk({n, ".hsync"}, hs_o, !(x >= ha + hfp && x < ha + hfp + hsw));
    chk({n, ".vsync"}, vs_o, !(y >= va + vfp && y < va + vfp + vsw));
    chk({n, ".video_active"}, act_o, a);
    chk({n, ".pix_x"}, px, a ? x : 0);
    chk({n, ".pix_y"}, py, a ? y : 0);
    chk({n, ".frame_start"}, fs, p == 0);
  endtask

  task automatic chk_reset(input string n, input logic hs_o, input logic vs_o, input logic act_o,
                           input logic [11:0] px, input logic [11:0] py, input logic fs, input logic mt);
    chk({n, ".rst_hsync"}, hs_o, 1);
    chk({n, ".rst_vsync"}, vs_o, 1);
    chk({n, ".rst_active"}, act_o, 0);
    chk({n, ".rst_pix_x"}, px, 0);
    chk({n, ".rst_pix_y"}, py, 0);
    chk({n, ".rst_frame_start"}, fs, 0);
    chk({n, ".rst_move_tick"}, mt, 0);
  endtask

  task automatic reset_all(input string n);
    chk_reset({n, ".a"}, hs_a, vs_a, va_a, px_a, py_a, fs_a, mt_a);
    chk_reset({n, ".b"}, hs_b, vs_b, va_b, px_b, py_b, fs_b, mt_b);
    chk_reset({n, ".d"}, hs_d, vs_d, va_d, px_d, py_d, fs_d, mt_d);
  endtask

  // One clock: compare output index k, then return at the falling edge for the next drive.
  task automatic step();
    bit vb, ea, eb;
    @(posedge clk);
    #1;
    vb = (k % FR) == VA * HT;
    ea = 1'b0;
    eb = 1'b0;
    if (!run_a) nva = 0;
    else if (vb) begin
      nva++;
      ea = (nva % 3) == 0;
    end
    if (!run_b) nvb = 0;
    else if (vb) begin
      nvb++;
      eb = (nvb % 2) == 0;
    end
    chk_raster("a", k, HA, HF, HS, HB, VA, VF, VS, VB, hs_a, vs_a, va_a, px_a, py_a, fs_a);
    chk("a.move_tick", mt_a, ea);
    chk_raster("b", k, HA, HF, HS, HB, VA, VF, VS, VB, hs_b, vs_b, va_b, px_b, py_b, fs_b);
    chk("b.move_tick", mt_b, eb);
    if (k < 1700) begin
      chk_raster("d", k, 640, 16, 96, 48, 480, 10, 2, 33, hs_d, vs_d, va_d, px_d, py_d, fs_d);
      chk("d.move_tick", mt_d, 0);
    end
    k++;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_all("por");
    run_a = 1'b1;
    run_b = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 9 * FR; i++) begin
      step();
      fs_cnt += int'(fs_a);
      tick_b += int'(mt_b);
      hl_cnt += int'(!hs_a);
      vl_cnt += int'(!vs_a);
      if (k % FR == 0 && k >= 4 * FR) run_a = 1'($urandom_range(0, 1));
      run_b = k >= 5 * FR;
    end
    chk("a.frame_start_count", fs_cnt, 9);
    chk("a.hsync_low_cycles", hl_cnt, 9 * VT * HS);
    chk("a.vsync_low_cycles", vl_cnt, 9 * VS * HT);
    chk("b.ticks_after_run", tick_b, 2);
    run_a = 1'b1;
    run_b = 1'b1;
    target = $urandom_range(2 * HT, FR - 1);
    repeat ((target - (k % FR) + FR) % FR) step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_all("async");
    repeat (2) @(negedge clk);
    reset_all("held");
    rst_n = 1'b1;
    k = 0;
    nva = 0;
    nvb = 0;
    for (int i = 0; i < 2 * FR; i++) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
